// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu32 execute-stage ALU: default datapath width,
// opcode encoding and the status-flag bundle.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH = 32;

    // Encodings 4'b1110 and 4'b1111 are deliberately absent: they are illegal
    // and produce a zero result with all flags except zero cleared.
    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_XOR  = 4'b0010,
        OP_NOR  = 4'b0011,
        OP_NAND = 4'b0100,
        OP_NOT  = 4'b0101,
        OP_ADD  = 4'b0110,
        OP_SUB  = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_MUL  = 4'b1001,
        OP_DIV  = 4'b1010,
        OP_MOD  = 4'b1011,
        OP_SLA  = 4'b1100,
        OP_SRA  = 4'b1101
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carryout;
        logic overflow;
    } alu_flags_t;

endpackage : alu_pkg

// File: rtl/alu_addsub.sv
// -----------------------------------------------------------------------------
// alu_addsub
// Shared adder for ADD, SUB and SLT. Subtraction is a + ~b + 1, so carry means
// "no borrow" (a >= b unsigned) when sub is set.
//   a, b      : operands
//   sub       : 1 = subtract, 0 = add
//   sum       : wrapped sum/difference
//   carry     : carry out of the MSB
//   overflow  : signed overflow of the operation
// -----------------------------------------------------------------------------
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    always_comb begin
        b_eff    = sub ? ~b : b;
        full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum      = full_sum[WIDTH-1:0];
        carry    = full_sum[WIDTH];
        // Overflow when the effective addends agree in sign but the sum does
        // not; for SUB this is "a and b differ in sign, result differs from a".
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule : alu_addsub

// File: rtl/alu32.sv
// -----------------------------------------------------------------------------
// alu32
// Signed integer ALU with a one-cycle registered result. An operation is
// accepted on each rising clk edge with valid_i high; result and flags appear
// the following cycle with valid_o high. With valid_i low, valid_o drops and
// result/flags hold.
//   clk, rst_n          : clock, asynchronous active-low reset
//   valid_i, a, b, opcode : operation request
//   valid_o, result     : registered response
//   zero, negative      : derived from the result being registered
//   carryout            : unsigned carry, ADD/SUB only
//   overflow            : signed overflow, or divide/modulo by zero
// -----------------------------------------------------------------------------
module alu32
    import alu_pkg::*;
#(
    parameter int WIDTH     = alu_pkg::WIDTH,
    parameter int SHIFT_AMT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             valid_o,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carryout,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] NEG_ONE = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------- adder
    logic             is_sub;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;

    assign is_sub = (opcode == OP_SUB) || (opcode == OP_SLT);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (a),
        .b        (b),
        .sub      (is_sub),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    // ----------------------------------------------------- multiply / divide
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] product;
    logic                      mul_ovf;
    logic                      div_by_zero;
    logic                      div_min_neg1;
    logic signed [WIDTH-1:0]   divisor;
    logic signed [WIDTH-1:0]   quotient;
    logic signed [WIDTH-1:0]   remainder;

    always_comb begin
        a_ext   = {{WIDTH{a[WIDTH-1]}}, a};
        b_ext   = {{WIDTH{b[WIDTH-1]}}, b};
        product = a_ext * b_ext;
        // Representable iff the upper half plus the result sign bit are all
        // copies of the sign.
        mul_ovf = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));

        div_by_zero  = (b == '0);
        div_min_neg1 = (a == MIN_INT) && (b == NEG_ONE);
        // Both awkward cases divide by 1 instead: MIN/-1 then yields MIN with
        // remainder 0, and b=0 never reaches the divider.
        divisor   = (div_by_zero || div_min_neg1) ? $signed(ONE) : $signed(b);
        quotient  = $signed(a) / divisor;
        remainder = $signed(a) % divisor;
    end

    // ------------------------------------------------------- next-state logic
    logic [WIDTH-1:0] result_d, result_q;
    alu_flags_t       flags_d, flags_q;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] op_res;
    alu_flags_t       op_flags;

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statement can leave a variable unassigned and infer a latch.
    always_comb begin
        op_res   = '0;
        op_flags = '0;

        case (opcode)
            OP_AND:  op_res = a & b;
            OP_OR:   op_res = a | b;
            OP_XOR:  op_res = a ^ b;
            OP_NOR:  op_res = ~(a | b);
            OP_NAND: op_res = ~(a & b);
            OP_NOT:  op_res = ~a;
            OP_ADD, OP_SUB: begin
                op_res            = as_sum;
                op_flags.carryout = as_carry;
                op_flags.overflow = as_ovf;
            end
            // Signed less-than: sign of a-b corrected by its overflow.
            OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
            OP_MUL: begin
                op_res            = product[WIDTH-1:0];
                op_flags.overflow = mul_ovf;
            end
            OP_DIV: begin
                op_res            = div_by_zero ? '0 : quotient;
                op_flags.overflow = div_by_zero || div_min_neg1;
            end
            OP_MOD: begin
                op_res            = div_by_zero ? '0 : remainder;
                op_flags.overflow = div_by_zero;
            end
            OP_SLA:  op_res = a << SHIFT_AMT;
            OP_SRA:  op_res = $signed(a) >>> SHIFT_AMT;
            default: op_res = '0;
        endcase

        op_flags.zero     = (op_res == '0);
        op_flags.negative = op_res[WIDTH-1];

        valid_d  = valid_i;
        result_d = valid_i ? op_res   : result_q;
        flags_d  = valid_i ? op_flags : flags_q;
    end

    // ------------------------------------------------------- output register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign valid_o  = valid_q;
    assign result   = result_q;
    assign zero     = flags_q.zero;
    assign negative = flags_q.negative;
    assign carryout = flags_q.carryout;
    assign overflow = flags_q.overflow;

endmodule : alu32

// File: tb/tb_alu32.sv
// -----------------------------------------------------------------------------
// tb_alu32
// Directed-vector bench for alu32. Each step drives one operation on the
// falling edge and samples the registered response 1 time unit after the
// following rising edge. Flags are compared as {zero, negative, carryout,
// overflow}.
// -----------------------------------------------------------------------------
module tb_alu32;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  opcode;
    logic        valid_o;
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        carryout;
    logic        overflow;

    int vectors;
    int miscompares;

    alu32 #(.WIDTH(32), .SHIFT_AMT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .a        (a),
        .b        (b),
        .opcode   (opcode),
        .valid_o  (valid_o),
        .result   (result),
        .zero     (zero),
        .negative (negative),
        .carryout (carryout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one operation and check valid_o, result and flags next cycle.
    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_res, input logic [3:0] exp_flags);
        @(negedge clk);
        valid_i = 1'b1;
        opcode  = op;
        a       = av;
        b       = bv;
        @(posedge clk);
        #1;
        check({tag, ".valid"},  64'(valid_o), 64'(1'b1));
        check({tag, ".result"}, 64'(result), 64'(exp_res));
        check({tag, ".flags"},  64'({zero, negative, carryout, overflow}), 64'(exp_flags));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        opcode  = 4'b0000;
        a       = '0;
        b       = '0;

        // Reset state, then outputs stay 0 until an operation is accepted.
        #12;
        check("reset.outputs", 64'({valid_o, result, zero, negative, carryout, overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", 64'({valid_o, result, zero, negative, carryout, overflow}), 64'd0);

        do_op("and_1_0", OP_AND, 32'd1, 32'd0, 32'd0, 4'b1000);

        // Logic ops
        do_op("or_0_1",     OP_OR,   32'd0,   32'd1,   32'd1,        4'b0000);
        do_op("xor_1_1",    OP_XOR,  32'd1,   32'd1,   32'd0,        4'b1000);
        do_op("nor_1_0",    OP_NOR,  32'd1,   32'd0,   32'hFFFFFFFE, 4'b0100);
        do_op("nand_m54",   OP_NAND, -32'sd54, -32'sd32, 32'd63,     4'b0000);
        do_op("not_24",     OP_NOT,  32'd24,  32'd99,  32'hFFFFFFE7, 4'b0100);

        // Asynchronous reset between clock edges clears outputs at once.
        @(negedge clk);
        valid_i = 1'b1;
        opcode  = OP_NOT;
        a       = 32'd5;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'({valid_o, result, zero, negative, carryout, overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("and_after_rst", OP_AND, 32'd1, 32'd0, 32'd0, 4'b1000);

        // Arithmetic and flags
        do_op("add_ovf",    OP_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b0101);
        do_op("add_carry",  OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0,        4'b1010);
        do_op("sub_5_4",    OP_SUB, 32'd5,        32'd4, 32'd1,        4'b0010);
        do_op("sub_4_5",    OP_SUB, 32'd4,        32'd5, 32'hFFFFFFFF, 4'b0100);
        do_op("sub_ovf",    OP_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0011);
        do_op("slt_3_10",   OP_SLT, 32'd3,        32'd10, 32'd1,       4'b0000);
        do_op("slt_m5_3",   OP_SLT, -32'sd5,      32'd3,  32'd1,       4'b0000);
        do_op("slt_3_m5",   OP_SLT, 32'd3,        -32'sd5, 32'd0,      4'b1000);

        // Multiply / divide / modulo
        do_op("mul_4_2",    OP_MUL, 32'd4,     32'd2,     32'd8,        4'b0000);
        do_op("mul_ovf",    OP_MUL, 32'd65536, 32'd65536, 32'd0,        4'b1001);
        do_op("mul_m3_5",   OP_MUL, -32'sd3,   32'd5,     32'hFFFFFFF1, 4'b0100);
        do_op("div_10_5",   OP_DIV, 32'd10,    32'd5,     32'd2,        4'b0000);
        do_op("mod_4_3",    OP_MOD, 32'd4,     32'd3,     32'd1,        4'b0000);
        do_op("div_m7_2",   OP_DIV, -32'sd7,   32'd2,     32'hFFFFFFFD, 4'b0100);
        do_op("mod_m7_2",   OP_MOD, -32'sd7,   32'd2,     32'hFFFFFFFF, 4'b0100);
        do_op("div_by0",    OP_DIV, 32'd7,     32'd0,     32'd0,        4'b1001);
        do_op("mod_by0",    OP_MOD, 32'd7,     32'd0,     32'd0,        4'b1001);
        do_op("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0101);
        do_op("mod_min_m1", OP_MOD, 32'h80000000, 32'hFFFFFFFF, 32'd0,        4'b1000);

        // Shifts and illegal opcode
        do_op("sla_m2",     OP_SLA, -32'sd2,  32'd7,  32'hFFFFFFE0, 4'b0100);
        do_op("sra_8",      OP_SRA, 32'd8,    32'd1,  32'd0,        4'b1000);
        do_op("sra_m64",    OP_SRA, -32'sd64, 32'd1,  32'hFFFFFFFC, 4'b0100);
        do_op("illegal_e",  4'b1110, 32'd10,  32'd10, 32'd0,        4'b1000);
        do_op("illegal_f",  4'b1111, 32'hFFFFFFFF, 32'd1, 32'd0,    4'b1000);

        // Handshake: drop valid_i, result and flags hold.
        do_op("pre_hold",   OP_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0011);
        @(negedge clk);
        valid_i = 1'b0;
        opcode  = OP_AND;
        a       = 32'd0;
        b       = 32'd0;
        @(posedge clk);
        #1;
        check("hold.valid",  64'(valid_o), 64'd0);
        check("hold.result", 64'(result), 64'h7FFFFFFF);
        check("hold.flags",  64'({zero, negative, carryout, overflow}), 64'b0011);
        @(posedge clk);
        #1;
        check("hold2.result", 64'(result), 64'h7FFFFFFF);
        do_op("after_hold", OP_OR, 32'h00F0, 32'h000F, 32'h00FF, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu32
